alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Execute-stage ALU; sits directly downstream of the ALU control decoder and consumes its 4-bit Operation code.
- Takes the operand pair and Operation and computes Result, Zero, Overflow and Illegal.
- Outputs are registered behind a valid/ready handshake with a 2-entry skid buffer, so back-to-back issue runs at full throughput with registered ready.
- Output feeds the EX/MEM boundary and the branch logic (Zero).

Parameters:
- WIDTH, 64, operand/result width in bits (legal values 8..64)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- Flush  input  1  synchronous kill of all buffered entries (branch/exception redirect)
- InValid  input  1  upstream presents an operation
- InReady  output  1  stage can accept; registered
- A  input  WIDTH  operand 1 (rs1)
- B  input  WIDTH  operand 2 (rs2 or immediate)
- Operation  input  4  code from ALU control
- OutValid  output  1  Result/flags valid
- OutReady  input  1  downstream accepts
- Result  output  WIDTH  ALU result
- Zero  output  1  Result == 0
- Overflow  output  1  signed overflow (ADD/SUB only, else 0)
- Illegal  output  1  Operation not in the supported set

Behaviour:
- Reset (reset_n low, asynchronous): both entries invalid; OutValid=0, InReady=1, Result=0, Zero=0, Overflow=0, Illegal=0.
- Operation decode:
  - 4'b0000: AND, A & B.
  - 4'b0001: OR, A | B.
  - 4'b0010: ADD, A + B modulo 2^WIDTH.
  - 4'b0110: SUB, A - B modulo 2^WIDTH.
  - Any other code: Result=0, Zero=1, Illegal=1. The entry is still delivered; it is never dropped silently.
- Overflow rules:
  - ADD: A[msb]==B[msb] and Result[msb]!=A[msb].
  - SUB: A[msb]!=B[msb] and Result[msb]!=A[msb].
- Zero is computed from the final Result of the same entry.
- Accept and latency:
  - Accept occurs when InValid & InReady at the clock edge.
  - The result is computed combinationally at accept and stored.
  - Latency is 1 cycle: OutValid rises on the edge after acceptance when the main entry was empty or draining.
- Storage: main entry M drives the outputs; skid entry S holds one overflow entry.
- Per-edge state transitions (no Flush):
  - M empty: an accepted op loads into M.
  - M full and drained (OutValid & OutReady): M loads from S if S is full; else M loads the accepted op; else M becomes empty.
  - M full, not drained, op accepted: the op loads into S.
  - Same edge with drain, accept and S full: S moves to M and the new op moves to S. This cannot occur while InReady=0.
- InReady rule: InReady = !S_full, registered.
  - With OutReady held high, S never fills and throughput is 1 op/cycle.
  - The stall worst case is: OutReady drops, one more op is captured in S, and InReady goes low the next cycle.
- Output stability: while OutValid=1 and OutReady=0, Result, Zero, Overflow and Illegal hold stable.
- Flush:
  - On the edge with Flush=1, M and S are invalidated and OutValid=0 next cycle.
  - Any op accepted on that same edge is discarded.
  - InReady=1 next cycle.
  - Flush has priority over all other events.
- Reset mid-operation: both entries are lost immediately (asynchronous); no partial output is produced.
- No combinational path from OutReady to InReady.

Decomposition:
- Shared package alu_pkg:
  - Operation code constants OP_AND=4'b0000, OP_OR=4'b0001, OP_ADD=4'b0010, OP_SUB=4'b0110.
  - A packed entry struct {Result, Zero, Overflow, Illegal}.
- The ALU control decoder imports the same constants.
- One sub-module: alu_core (combinational A/B/Operation -> Result/Zero/Overflow/Illegal).
  - Instantiated once at the input side.
  - alu_exec_stage holds only the buffering and handshake FSM, with states EMPTY / ONE / TWO.

Test Plan:
1. Reset and single ops:
   - Stimulus: release reset; issue ADD A=5,B=7, then SUB A=7,B=7, then AND A=0xF0,B=0x3C, then OR A=0xF0,B=0x0F; OutReady=1.
   - Required: Result=12, then 0 with Zero=1, then 0x30, then 0xFF; each 1 cycle after accept.
2. Overflow:
   - Stimulus: ADD A=0x7FFF_FFFF_FFFF_FFFF, B=1.
   - Required: Result=0x8000_0000_0000_0000, Overflow=1.
   - Stimulus: SUB A=0x8000_0000_0000_0000, B=1.
   - Required: Overflow=1.
   - Stimulus: AND of the same operands.
   - Required: Overflow=0.
3. Illegal code:
   - Stimulus: Operation=4'b1111, A=3,B=4.
   - Required: OutValid=1, Result=0, Zero=1, Illegal=1.
4. Backpressure:
   - Stimulus: stream 4 ADDs (1+1, 2+2, 3+3, 4+4) with InValid=1; OutReady=0 from cycle 1.
   - Required: 2 ops captured; InReady=0 from the cycle after the 2nd accept; outputs hold 2 stable.
   - Stimulus: raise OutReady.
   - Required: 2, 4, 6, 8 delivered in order with no loss or duplication.
5. Flush:
   - Stimulus: with M and S full, assert Flush together with InValid.
   - Required: next cycle OutValid=0, InReady=1; the flushed and same-edge ops never appear.
6. Async reset mid-stall:
   - Stimulus: assert reset_n=0 mid-cycle while OutValid=1.
   - Required: OutValid=0 and Result=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes used by ALU control and the execute stage,
// the buffered result entry, and the execute-stage buffer states.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    // Entries are sized for the widest legal datapath; narrower stages use the low bits.
    localparam int ALU_MAX_WIDTH = 64;

    typedef struct packed {
        logic [ALU_MAX_WIDTH-1:0] result;
        logic                     zero;
        logic                     overflow;
        logic                     illegal;
    } alu_entry_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } alu_buf_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: computes result and flags for one operand pair.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (operation)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD: begin
                result   = a + b;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result   = a - b;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            default: illegal = 1'b1;
        endcase
    end

    // Illegal codes leave result at zero, so zero is asserted for them as well.
    assign zero = (result == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with a registered-ready, two-entry skid buffer in front of EX/MEM.
// Entry M drives the outputs; entry S catches the one op accepted while M is stalled.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Operation,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             Illegal
);

    logic [WIDTH-1:0] core_result;
    logic             core_zero;
    logic             core_overflow;
    logic             core_illegal;
    alu_entry_t       new_entry;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a         (A),
        .b         (B),
        .operation (Operation),
        .result    (core_result),
        .zero      (core_zero),
        .overflow  (core_overflow),
        .illegal   (core_illegal)
    );

    always_comb begin
        new_entry.result   = ALU_MAX_WIDTH'(core_result);
        new_entry.zero     = core_zero;
        new_entry.overflow = core_overflow;
        new_entry.illegal  = core_illegal;
    end

    alu_buf_state_e state_reg, state_next;
    alu_entry_t     m_reg, m_next;
    alu_entry_t     s_reg, s_next;
    logic           in_ready_reg, in_ready_next;
    logic           accept;
    logic           drain;

    assign accept = InValid && in_ready_reg;
    assign drain  = (state_reg != BUF_EMPTY) && OutReady;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= BUF_EMPTY;
            m_reg        <= '0;
            s_reg        <= '0;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            m_reg        <= m_next;
            s_reg        <= s_next;
            in_ready_reg <= in_ready_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        m_next     = m_reg;
        s_next     = s_reg;
        if (Flush) begin
            state_next = BUF_EMPTY;
            m_next     = '0;
            s_next     = '0;
        end else begin
            case (state_reg)
                BUF_EMPTY: begin
                    if (accept) begin
                        m_next     = new_entry;
                        state_next = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (drain && accept) begin
                        m_next = new_entry;
                    end else if (drain) begin
                        m_next     = '0;
                        state_next = BUF_EMPTY;
                    end else if (accept) begin
                        s_next     = new_entry;
                        state_next = BUF_TWO;
                    end
                end
                BUF_TWO: begin
                    // Accept is normally blocked here by the registered ready.
                    if (drain) begin
                        m_next = s_reg;
                        if (accept) begin
                            s_next = new_entry;
                        end else begin
                            s_next     = '0;
                            state_next = BUF_ONE;
                        end
                    end
                end
                default: begin
                    state_next = BUF_EMPTY;
                    m_next     = '0;
                    s_next     = '0;
                end
            endcase
        end
    end

    // Ready depends only on the next buffer occupancy, never on OutReady combinationally.
    assign in_ready_next = (state_next != BUF_TWO);

    assign InReady  = in_ready_reg;
    assign OutValid = (state_reg != BUF_EMPTY);
    assign Result   = m_reg.result[WIDTH-1:0];
    assign Zero     = m_reg.zero;
    assign Overflow = m_reg.overflow;
    assign Illegal  = m_reg.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios then random traffic,
// checked every cycle against a queue-based reference of the buffered results.
module tb_alu_exec_stage;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         Flush;
    logic         InValid;
    logic         InReady;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   Operation;
    logic         OutValid;
    logic         OutReady;
    logic [W-1:0] Result;
    logic         Zero;
    logic         Overflow;
    logic         Illegal;

    always #5 clk = ~clk;

    alu_exec_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Flush     (Flush),
        .InValid   (InValid),
        .InReady   (InReady),
        .A         (A),
        .B         (B),
        .Operation (Operation),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .Result    (Result),
        .Zero      (Zero),
        .Overflow  (Overflow),
        .Illegal   (Illegal)
    );

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         o;
        logic         il;
    } exp_t;

    exp_t         exp_q[$];
    logic         exp_ready;
    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] delivered[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact signed arithmetic in W+2 bits; overflow means the true value
    // does not fit back into W bits.
    function automatic exp_t model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [3:0] op);
        exp_t         e;
        logic [W+1:0] wa;
        logic [W+1:0] wb;
        logic [W+1:0] wide;
        e.r  = '0;
        e.o  = 1'b0;
        e.il = 1'b0;
        wa   = {{2{a[W-1]}}, a};
        wb   = {{2{b[W-1]}}, b};
        case (op)
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b0010: begin
                wide = wa + wb;
                e.r  = wide[W-1:0];
                e.o  = (wide != {{2{e.r[W-1]}}, e.r});
            end
            4'b0110: begin
                wide = wa - wb;
                e.r  = wide[W-1:0];
                e.o  = (wide != {{2{e.r[W-1]}}, e.r});
            end
            default: e.il = 1'b1;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    task automatic check_outputs();
        check("in_ready", 64'(InReady), 64'(exp_ready));
        check("out_valid", 64'(OutValid), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check("result", 64'(Result), 64'(exp_q[0].r));
            check("zero", 64'(Zero), 64'(exp_q[0].z));
            check("overflow", 64'(Overflow), 64'(exp_q[0].o));
            check("illegal", 64'(Illegal), 64'(exp_q[0].il));
        end
    endtask

    // One clock: drive inputs (called just after a falling edge), advance the
    // reference on the rising edge, then check outputs on the next falling edge.
    task automatic step(input logic fl, input logic inv, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [3:0] op, input logic ordy,
                        output bit accepted);
        bit   drain;
        bit   acc;
        exp_t e;
        Flush     = fl;
        InValid   = inv;
        A         = a;
        B         = b;
        Operation = op;
        OutReady  = ordy;
        @(posedge clk);
        accepted = 1'b0;
        if (fl) begin
            exp_q.delete();
            exp_ready = 1'b1;
        end else begin
            drain = (exp_q.size() > 0) && ordy;
            acc   = inv && exp_ready;
            if (drain) begin
                e = exp_q.pop_front();
                $display("deliver result=%h zero=%0b ovf=%0b ill=%0b", e.r, e.z, e.o, e.il);
            end
            if (acc) begin
                exp_q.push_back(model_op(a, b, op));
                accepted = 1'b1;
                $display("accept  op=%b a=%h b=%h", op, a, b);
            end
            exp_ready = (exp_q.size() < 2);
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic ordy);
        bit acc;
        step(1'b0, 1'b0, '0, '0, 4'b0000, ordy, acc);
    endtask

    bit           acc;
    int           idx;
    logic [W-1:0] big_pos;
    logic [W-1:0] big_neg;
    logic [3:0]   op_pick[5];
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [3:0]   rop;

    initial begin
        big_pos    = {1'b0, {(W-1){1'b1}}};
        big_neg    = {1'b1, {(W-1){1'b0}}};
        op_pick[0] = 4'b0000;
        op_pick[1] = 4'b0001;
        op_pick[2] = 4'b0010;
        op_pick[3] = 4'b0110;
        op_pick[4] = 4'b1111;

        reset_n   = 1'b0;
        Flush     = 1'b0;
        InValid   = 1'b0;
        A         = '0;
        B         = '0;
        Operation = 4'b0000;
        OutReady  = 1'b0;
        exp_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(OutValid), 64'(0));
        check("rst_in_ready", 64'(InReady), 64'(1));
        check("rst_result", 64'(Result), 64'(0));
        check("rst_zero", 64'(Zero), 64'(0));
        check("rst_overflow", 64'(Overflow), 64'(0));
        check("rst_illegal", 64'(Illegal), 64'(0));
        reset_n = 1'b1;

        // Single ops, one cycle latency
        step(1'b0, 1'b1, 64'd5, 64'd7, 4'b0010, 1'b1, acc);
        check("t1_add", 64'(Result), 64'd12);
        step(1'b0, 1'b1, 64'd7, 64'd7, 4'b0110, 1'b1, acc);
        check("t1_sub", 64'(Result), 64'd0);
        check("t1_sub_zero", 64'(Zero), 64'(1));
        step(1'b0, 1'b1, 64'hF0, 64'h3C, 4'b0000, 1'b1, acc);
        check("t1_and", 64'(Result), 64'h30);
        step(1'b0, 1'b1, 64'hF0, 64'h0F, 4'b0001, 1'b1, acc);
        check("t1_or", 64'(Result), 64'hFF);

        // Overflow boundaries
        step(1'b0, 1'b1, big_pos, 64'd1, 4'b0010, 1'b1, acc);
        check("t2_add_res", 64'(Result), 64'(big_neg));
        check("t2_add_ovf", 64'(Overflow), 64'(1));
        step(1'b0, 1'b1, big_neg, 64'd1, 4'b0110, 1'b1, acc);
        check("t2_sub_ovf", 64'(Overflow), 64'(1));
        step(1'b0, 1'b1, big_neg, 64'd1, 4'b0000, 1'b1, acc);
        check("t2_and_ovf", 64'(Overflow), 64'(0));

        // Illegal code still delivered
        step(1'b0, 1'b1, 64'd3, 64'd4, 4'b1111, 1'b1, acc);
        check("t3_valid", 64'(OutValid), 64'(1));
        check("t3_result", 64'(Result), 64'd0);
        check("t3_zero", 64'(Zero), 64'(1));
        check("t3_illegal", 64'(Illegal), 64'(1));
        idle(1'b1);

        // Backpressure: only two ops fit while OutReady is low
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, idx < 4, W'(idx + 1), W'(idx + 1), 4'b0010, 1'b0, acc);
            if (acc) idx++;
        end
        check("t4_captured", 64'(idx), 64'd2);
        check("t4_in_ready", 64'(InReady), 64'(0));
        check("t4_hold", 64'(Result), 64'd2);
        delivered.delete();
        for (int c = 0; c < 12; c++) begin
            if (OutValid) delivered.push_back(Result);
            step(1'b0, idx < 4, W'(idx + 1), W'(idx + 1), 4'b0010, 1'b1, acc);
            if (acc) idx++;
        end
        check("t4_count", 64'(delivered.size()), 64'd4);
        for (int k = 0; k < 4 && k < delivered.size(); k++) begin
            check("t4_order", 64'(delivered[k]), 64'(2 * (k + 1)));
        end

        // Flush with both entries full and a same-edge op
        step(1'b0, 1'b1, 64'd10, 64'd10, 4'b0010, 1'b0, acc);
        step(1'b0, 1'b1, 64'd20, 64'd20, 4'b0010, 1'b0, acc);
        check("t5_full", 64'(InReady), 64'(0));
        step(1'b1, 1'b1, 64'd30, 64'd30, 4'b0010, 1'b0, acc);
        check("t5_out_valid", 64'(OutValid), 64'(0));
        check("t5_in_ready", 64'(InReady), 64'(1));
        for (int c = 0; c < 3; c++) idle(1'b1);

        // Asynchronous reset while stalled
        step(1'b0, 1'b1, 64'd9, 64'd9, 4'b0010, 1'b0, acc);
        check("t6_pre_valid", 64'(OutValid), 64'(1));
        InValid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("t6_out_valid", 64'(OutValid), 64'(0));
        check("t6_result", 64'(Result), 64'd0);
        check("t6_in_ready", 64'(InReady), 64'(1));
        exp_q.delete();
        exp_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        check_outputs();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            rop = op_pick[$urandom_range(0, 4)];
            if (rop == 4'b1111) rop = 4'($urandom);
            case ($urandom_range(0, 5))
                0: ra = big_pos;
                1: ra = big_neg;
                default: ra = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 5))
                0: rb = 64'd1;
                1: rb = ra;
                default: rb = {$urandom, $urandom};
            endcase
            step($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, ra, rb, rop,
                 $urandom_range(0, 9) < 6, acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
